// File: rtl/dpa_frame_ctrl_if.sv
// Memory bus and status bundle for the DPA frame controller.
// The controller side uses the master modport; memory/host side uses slave.
interface dpa_frame_ctrl_if #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned MAX_PHOTOS = 4
);
  localparam int unsigned IDX_W = (MAX_PHOTOS > 1) ? $clog2(MAX_PHOTOS) : 1;

  logic              pause;
  logic [DATA_W-1:0] im_rdata;
  logic [ADDR_W-1:0] im_a;
  logic              im_wen_n;
  logic [DATA_W-1:0] im_wdata;
  logic [23:0]       curr_time;
  logic [IDX_W-1:0]  photo_idx;
  logic              frame_busy;
  logic              overrun;

  modport master (
    input  pause, im_rdata,
    output im_a, im_wen_n, im_wdata, curr_time, photo_idx, frame_busy, overrun
  );

  modport slave (
    output pause, im_rdata,
    input  im_a, im_wen_n, im_wdata, curr_time, photo_idx, frame_busy, overrun
  );
endinterface

// File: rtl/dpa_frame_ctrl.sv
// DPA frame controller: boots from an image-memory header, then once per
// display period copies one photo into the frame buffer and appends the
// current hh:mm:ss time word. Supports pause and sticky overrun reporting.
module dpa_frame_ctrl #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned MAX_PHOTOS = 4,
  parameter int unsigned FB_PIX     = 16384,
  parameter int unsigned PERIOD     = 1000000
) (
  input logic              clk,
  input logic              reset,
  dpa_frame_ctrl_if.master bus
);
  localparam int unsigned IDX_W    = (MAX_PHOTOS > 1) ? $clog2(MAX_PHOTOS) : 1;
  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam int unsigned COPY_LEN = 2 * FB_PIX + 2;
  localparam int unsigned CW       = $clog2(COPY_LEN);
  localparam int unsigned PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {
    StSetup, StLoadDesc, StDescWait, StCopy, StOverlay, StIdle
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        setup_q, setup_d;
  logic [CW-1:0]     copy_q, copy_d;
  logic [PW-1:0]     per_q, per_d;
  logic [23:0]       time_q, time_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fb_q, fb_d, base_q, base_d, a_hold_q;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pend_q, pend_d, ovr_q, ovr_d;

  logic [ADDR_W-1:0] a_cur;
  logic              wen_n_cur, wrap, busy;
  logic [CNT_W-1:0]  cnt_raw;

  assign wrap    = (per_q == PW'(PERIOD - 1)) && !bus.pause;
  assign busy    = state_q inside {StLoadDesc, StDescWait, StCopy, StOverlay};
  assign cnt_raw = bus.im_rdata[IDX_W:0];

  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [7:0] hh, mm, ss;
    {hh, mm, ss} = t;
    if (ss != 8'd59) begin
      ss = ss + 8'd1;
    end else begin
      ss = 8'd0;
      if (mm != 8'd59) begin
        mm = mm + 8'd1;
      end else begin
        mm = 8'd0;
        hh = (hh == 8'd23) ? 8'd0 : hh + 8'd1;
      end
    end
    return {hh, mm, ss};
  endfunction

  // Next state plus the memory address / write strobe of the current cycle.
  always_comb begin
    state_d   = state_q;
    a_cur     = a_hold_q;
    wen_n_cur = 1'b1;
    unique case (state_q)
      StSetup: begin
        if (setup_q != 2'd3) a_cur = ADDR_W'(setup_q);
        else                 state_d = StLoadDesc;
      end
      StLoadDesc: begin
        a_cur   = ADDR_W'(3) + ADDR_W'(idx_q);
        state_d = StDescWait;
      end
      StDescWait: state_d = StCopy;
      StCopy: begin
        // Even cycles read pixel c/2; odd cycles from 3 write pixel (c-3)/2.
        if (!copy_q[0]) begin
          if (copy_q < CW'(2 * FB_PIX)) a_cur = base_q + ADDR_W'(copy_q >> 1);
        end else if (copy_q >= CW'(3)) begin
          a_cur     = fb_q + ADDR_W'((copy_q - CW'(3)) >> 1);
          wen_n_cur = 1'b0;
        end
        if (copy_q == CW'(COPY_LEN - 1)) state_d = StOverlay;
      end
      StOverlay: begin
        a_cur     = fb_q + ADDR_W'(FB_PIX);
        wen_n_cur = 1'b0;
        state_d   = (pend_q || wrap) ? StLoadDesc : StIdle;
      end
      StIdle: if (pend_q || wrap) state_d = StLoadDesc;
      default: state_d = StSetup;
    endcase
  end

  // Datapath next-state: header capture, copy sequencing, period and time keeping.
  always_comb begin
    setup_d = setup_q;
    copy_d  = copy_q;
    per_d   = per_q;
    time_d  = time_q;
    idx_d   = idx_q;
    count_d = count_q;
    fb_d    = fb_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    pend_d  = pend_q | wrap;
    ovr_d   = ovr_q | (wrap & busy);
    if (!bus.pause) per_d = wrap ? '0 : per_q + 1'b1;
    if (wrap) begin
      time_d = time_inc(time_q);
      idx_d  = ({1'b0, idx_q} == count_q - 1'b1) ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      StSetup: begin
        setup_d = setup_q + 2'd1;
        case (setup_q)
          2'd1: time_d = bus.im_rdata[23:0];
          2'd2: fb_d = bus.im_rdata[ADDR_W-1:0];
          2'd3: count_d = (cnt_raw == '0 || cnt_raw > CNT_W'(MAX_PHOTOS))
                          ? CNT_W'(MAX_PHOTOS) : cnt_raw;
          default: ;
        endcase
      end
      StDescWait: begin
        base_d = bus.im_rdata[ADDR_W-1:0];
        copy_d = '0;
      end
      StCopy: begin
        copy_d = copy_q + 1'b1;
        if (copy_q[0]) wdata_d = bus.im_rdata;
      end
      default: ;
    endcase
    // A frame launched from IDLE or straight after OVERLAY consumes the request.
    if (state_d == StLoadDesc && (state_q == StIdle || state_q == StOverlay)) pend_d = 1'b0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StSetup;
      setup_q  <= '0;
      copy_q   <= '0;
      per_q    <= '0;
      time_q   <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      fb_q     <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      a_hold_q <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      setup_q  <= setup_d;
      copy_q   <= copy_d;
      per_q    <= per_d;
      time_q   <= time_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      fb_q     <= fb_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      a_hold_q <= a_cur;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  // Reset masks the strobe so an aborted copy cannot write in the reset cycle.
  assign bus.im_a       = a_cur;
  assign bus.im_wen_n   = wen_n_cur | reset;
  assign bus.im_wdata   = (state_q == StOverlay) ? DATA_W'(time_q) : wdata_q;
  assign bus.curr_time  = time_q;
  assign bus.photo_idx  = idx_q;
  assign bus.frame_busy = busy;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_dpa_frame_ctrl.sv
// Bench for dpa_frame_ctrl: instance A (PERIOD=20) checked by a write scoreboard
// plus directed probes; instance B (PERIOD=8) exercises overrun.
module tb_dpa_frame_ctrl;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 24;
  localparam int unsigned MP = 4;
  localparam int unsigned FP = 4;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  dpa_frame_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .MAX_PHOTOS(MP)) bus_a ();
  dpa_frame_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .MAX_PHOTOS(MP)) bus_b ();

  dpa_frame_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_PHOTOS(MP), .FB_PIX(FP), .PERIOD(20))
    u_dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  dpa_frame_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_PHOTOS(MP), .FB_PIX(FP), .PERIOD(8))
    u_dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  // Read-only image memory shared by both instances; writes go to the scoreboard.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    bus_a.im_rdata <= mem[bus_a.im_a[8:0]];
    bus_b.im_rdata <= mem[bus_b.im_a[8:0]];
  end

  int errors = 0;
  int n_checks = 0;
  int cyc = 0;
  logic [AW-1:0] exp_a [$];
  logic [DW-1:0] exp_d [$];
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] pix0, input logic [DW-1:0] tword);
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(AW'(32'h100 + i));
      exp_d.push_back(pix0 + DW'(i));
    end
    exp_a.push_back(AW'(32'h104));
    exp_d.push_back(tword);
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_reset_a();
    chk("rst_im_a", 32'(bus_a.im_a), 32'h0);
    chk("rst_wen_n", 32'(bus_a.im_wen_n), 32'h1);
    chk("rst_wdata", 32'(bus_a.im_wdata), 32'h0);
    chk("rst_time", 32'(bus_a.curr_time), 32'h0);
    chk("rst_idx", 32'(bus_a.photo_idx), 32'h0);
    chk("rst_busy", 32'(bus_a.frame_busy), 32'h0);
    chk("rst_overrun", 32'(bus_a.overrun), 32'h0);
  endtask

  // Called at a negedge: reset for one edge, check cycle 0, then release.
  task automatic reset_a();
    #1 rst_a = 1'b1;
    @(negedge clk);
    cyc = 0;
    chk_reset_a();
    #1 rst_a = 1'b0;
  endtask

  // Scoreboard monitor: every write strobe on A pops one expected write.
  always @(negedge clk) begin
    if (bus_a.im_wen_n === 1'b0) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h want none", bus_a.im_a,
                 bus_a.im_wdata);
      end else begin
        ea = exp_a.pop_front();
        ed = exp_d.pop_front();
        chk("wr_addr", 32'(bus_a.im_a), 32'(ea));
        chk("wr_data", 32'(bus_a.im_wdata), 32'(ed));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus_a.pause = 1'b0;
    bus_b.pause = 1'b0;
    mem[0] = 24'h0A0B3B;
    mem[1] = 24'h000100;
    mem[2] = 24'h000002;
    mem[3] = 24'h000040;
    mem[4] = 24'h000080;
    for (int i = 0; i < 4; i++) begin
      mem[9'h40 + i] = 24'h111100 + DW'(i);
      mem[9'h80 + i] = 24'h222200 + DW'(i);
    end

    // Boot and three frames: photo order 0,1,0.
    reset_a();
    push_frame(24'h111100, 24'h0A0B3B);
    push_frame(24'h222200, 24'h0A0C00);
    push_frame(24'h111100, 24'h0A0C01);
    goto(1);  chk("hdr_rd1", 32'(bus_a.im_a), 32'h1);
    goto(2);  chk("hdr_rd2", 32'(bus_a.im_a), 32'h2);
    goto(4);  chk("desc_rd", 32'(bus_a.im_a), 32'h3);
    chk("busy_first", 32'(bus_a.frame_busy), 32'h1);
    chk("init_time", 32'(bus_a.curr_time), 32'h0A0B3B);
    goto(20); chk("wrap1_time", 32'(bus_a.curr_time), 32'h0A0C00);
    chk("wrap1_idx", 32'(bus_a.photo_idx), 32'h1);
    chk("desc_rd_idx1", 32'(bus_a.im_a), 32'h4);
    goto(40); chk("wrap2_idx", 32'(bus_a.photo_idx), 32'h0);
    chk("desc_rd_idx0", 32'(bus_a.im_a), 32'h3);
    goto(54); chk("q_empty1", 32'(exp_a.size()), 32'h0);
    chk("no_overrun", 32'(bus_a.overrun), 32'h0);

    // Pause for 30 edges starting at period count 15: next wrap moves to cycle 89.
    push_frame(24'h222200, 24'h0A0C02);
    goto(55); #1 bus_a.pause = 1'b1;
    goto(60); chk("pause_busy", 32'(bus_a.frame_busy), 32'h0);
    chk("pause_time", 32'(bus_a.curr_time), 32'h0A0C01);
    goto(85); chk("pause_idx", 32'(bus_a.photo_idx), 32'h0);
    chk("pause_time2", 32'(bus_a.curr_time), 32'h0A0C01);
    #1 bus_a.pause = 1'b0;
    goto(89); chk("resume_idle", 32'(bus_a.frame_busy), 32'h0);
    goto(90); chk("resume_busy", 32'(bus_a.frame_busy), 32'h1);
    chk("resume_time", 32'(bus_a.curr_time), 32'h0A0C02);
    chk("resume_idx", 32'(bus_a.photo_idx), 32'h1);
    goto(104); chk("q_empty2", 32'(exp_a.size()), 32'h0);

    // Midnight roll-over.
    mem[0] = 24'h173B3B;
    reset_a();
    push_frame(24'h111100, 24'h173B3B);
    push_frame(24'h222200, 24'h000000);
    goto(2);  chk("midn_init", 32'(bus_a.curr_time), 32'h173B3B);
    goto(20); chk("midn_wrap", 32'(bus_a.curr_time), 32'h000000);
    goto(34); chk("q_empty3", 32'(exp_a.size()), 32'h0);

    // Reset in the middle of COPY (copy cycle 6), then full reboot.
    mem[0] = 24'h0A0B3B;
    reset_a();
    exp_a.push_back(AW'(32'h100)); exp_d.push_back(24'h111100);
    exp_a.push_back(AW'(32'h101)); exp_d.push_back(24'h111101);
    goto(12); chk("mid_copy_busy", 32'(bus_a.frame_busy), 32'h1);
    reset_a();
    push_frame(24'h111100, 24'h0A0B3B);
    goto(1);  chk("reread_hdr", 32'(bus_a.im_a), 32'h1);
    goto(4);  chk("reread_desc", 32'(bus_a.im_a), 32'h3);
    goto(18); chk("q_empty4", 32'(exp_a.size()), 32'h0);
    chk("reboot_time", 32'(bus_a.curr_time), 32'h0A0B3B);
    #1 rst_a = 1'b1;

    // Instance B: PERIOD=8 wraps at 7 and 15 during the first frame.
    @(negedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    cyc = 0;
    #1 rst_b = 1'b0;
    goto(7);  chk("b_ovr_before", 32'(bus_b.overrun), 32'h0);
    goto(8);  chk("b_ovr_set", 32'(bus_b.overrun), 32'h1);
    chk("b_idx_wrap", 32'(bus_b.photo_idx), 32'h1);
    goto(16); chk("b_ovl_wen", 32'(bus_b.im_wen_n), 32'h0);
    chk("b_ovl_addr", 32'(bus_b.im_a), 32'h104);
    chk("b_ovl_data", 32'(bus_b.im_wdata), 32'h0A0C01);
    goto(17); chk("b_pend_busy", 32'(bus_b.frame_busy), 32'h1);
    chk("b_pend_desc", 32'(bus_b.im_a), 32'h3);
    goto(30); chk("b_pend2_desc", 32'(bus_b.im_a), 32'h4);
    chk("b_ovr_sticky", 32'(bus_b.overrun), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule
